instr_decoder_pipe: RTL and testbench
=====================================

// Module: instr_decoder_pipe
// PURPOSE
//  Registered, parametrised instruction decode stage between instruction fetch and the ALU/register file.
//  Decodes a class field plus a register-address field into an ALU opcode, accumulator enable,
//  register-read select and one-hot register write enables.
//  Valid/ready handshakes on both sides; 1-cycle latency.
//  Adds three things a purely combinational decoder cannot do: stall for multi-cycle multiply,
//  a HALT state with external resume, and illegal-opcode flagging.
// PARAMETERS
//  REG_ADDR_W  2  register address width; NUM_REGS = 2**REG_ADDR_W
//  OPC_W       3  ALU opcode width; class field F width FW = OPC_W+1 (OPC_W>=3 required)
//  MUL_LAT     3  multiply (F=5) occupancy in cycles, >=1
//  INSTR_W is derived, not settable: INSTR_W = FW+REG_ADDR_W (6 at defaults)
// PORTS
//  clk            in   1         clock, rising edge
//  rst            in   1         asynchronous, active-high reset
//  in_valid       in   1         in_instr valid
//  in_ready       out  1         decoder accepts in_instr this cycle
//  in_instr       in   INSTR_W   F = [INSTR_W-1:REG_ADDR_W], R = [REG_ADDR_W-1:0]
//  out_valid      out  1         decoded payload valid
//  out_ready      in   1         downstream consumes payload this cycle
//  out_opcode     out  OPC_W     ALU operation
//  out_aku_en     out  1         ALU result written to accumulator
//  out_reg_rd_en  out  1         ALU second operand taken from register out_reg_addr
//  out_reg_addr   out  REG_ADDR_W register index for read (F=6) or write (F=7)
//  out_reg_we     out  NUM_REGS  one-hot register write enable (accumulator -> reg)
//  out_illegal    out  1         payload is an illegal instruction
//  resume         in   1         leave HALTED state
//  halted         out  1         FSM is in HALTED
// BEHAVIOUR
//  Decode of F (values fixed regardless of OPC_W):
//   - 0..5: opcode=F, aku_en=1
//   - 6: opcode=6, aku_en=1, rd_en=1, addr=R
//   - 7: we[R]=1, addr=R, opcode=0, aku_en=0
//   - 8 (NOP) / 9 (HALT): all payload fields 0
//   - >=10: illegal=1, all other payload fields 0
//  Payload outputs are forced to 0 whenever out_valid=0; out_reg_we is one-hot or zero, never multi-hot.
//  Reset (async, any state, including mid-MUL_WAIT):
//   - state=RUN, out_valid=0, all payload outputs 0, halted=0, multiply counter=0
//   - the in-progress instruction is discarded
//  Handshake:
//   - in_ready = (state==RUN) && (!out_valid || out_ready)
//   - accept = in_valid && in_ready; payload registered on that edge, out_valid=1 next cycle (latency 1)
//   - out_valid && !out_ready: payload held bit-stable; no input accepted
//   - out_ready && !accept: out_valid clears next edge
//   - back-to-back accepts give full throughput; no drop, no duplicate
//  FSM states RUN, MUL_WAIT, HALTED:
//   - RUN -> MUL_WAIT on accept of F=5 when MUL_LAT>1; counter loads MUL_LAT-1
//   - MUL_WAIT: in_ready=0, counter decrements each cycle, -> RUN when counter reaches 0,
//     so in_ready is low for exactly MUL_LAT-1 cycles after the accept edge. MUL_LAT=1: no wait.
//   - RUN -> HALTED on accept of F=9; the HALT payload is still emitted on the output.
//   - HALTED: in_ready=0, halted=1; resume sampled high -> RUN next edge.
//   - resume in RUN/MUL_WAIT is ignored, including in the same cycle a HALT is accepted.
//   - illegal instructions do not change state.
//  Output-side stalls and FSM waits are independent; in_ready requires both to be clear.
// TESTING
//  - reset, in_instr=6'b000100, out_ready=1 -> next cycle out_valid=1, opcode=1, aku_en=1, we=4'b0000
//  - 6'b011110 -> we=4'b0100, addr=2, aku_en=0; 6'b011001 -> opcode=6, aku_en=1, rd_en=1, addr=1
//  - out_ready=0 for 2 cycles with stream 6'b000100, 6'b001000 -> in_ready=0, payload held;
//    release -> both delivered in order, none lost or duplicated
//  - MUL_LAT=3, 6'b010100 accepted -> in_ready=0 exactly 2 cycles, then 1; payload opcode=5, aku_en=1
//  - 6'b100100 (HALT) -> halted=1, in_ready=0 for 10 cycles; resume=1 one cycle -> halted=0, in_ready=1 next cycle
//  - 6'b101100 -> out_illegal=1, other fields 0, state RUN; rst asserted during MUL_WAIT -> out_valid=0, in_ready=1 after release

Source files
------------

// File: rtl/instr_decoder_pipe.sv
// Registered instruction decode stage: class/register fields to ALU controls,
// with valid/ready on both sides, multiply stall, HALT/resume and illegal flagging.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | accepting instructions whenever the output slot is free
// ST_MUL_WAIT | multiply occupying the ALU; counter runs down to zero
// ST_HALTED   | HALT accepted; waits for resume
module instr_decoder_pipe #(
    parameter int REG_ADDR_W = 2,
    parameter int OPC_W      = 3,
    parameter int MUL_LAT    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OPC_W+REG_ADDR_W:0]     in_instr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OPC_W-1:0]              out_opcode,
    output logic                          out_aku_en,
    output logic                          out_reg_rd_en,
    output logic [REG_ADDR_W-1:0]         out_reg_addr,
    output logic [(2**REG_ADDR_W)-1:0]    out_reg_we,
    output logic                          out_illegal,
    input  logic                          resume,
    output logic                          halted
);

    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam int FW       = OPC_W + 1;
    localparam int INSTR_W  = FW + REG_ADDR_W;
    localparam int CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam bit MUL_STALL = (MUL_LAT > 1);

    localparam logic [FW-1:0] F_MUL  = FW'(5);
    localparam logic [FW-1:0] F_RD   = FW'(6);
    localparam logic [FW-1:0] F_WR   = FW'(7);
    localparam logic [FW-1:0] F_NOP  = FW'(8);
    localparam logic [FW-1:0] F_HALT = FW'(9);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic [OPC_W-1:0]        opcode_q, opcode_d;
    logic                    aku_en_q, aku_en_d;
    logic                    rd_en_q, rd_en_d;
    logic [REG_ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_REGS-1:0]     we_q, we_d;
    logic                    illegal_q, illegal_d;

    logic [FW-1:0]           f_fld;
    logic [REG_ADDR_W-1:0]   r_fld;
    logic [OPC_W-1:0]        dec_opcode;
    logic                    dec_aku_en;
    logic                    dec_rd_en;
    logic [REG_ADDR_W-1:0]   dec_addr;
    logic [NUM_REGS-1:0]     dec_we;
    logic                    dec_illegal;
    logic                    accept;

    assign f_fld = in_instr[INSTR_W-1:REG_ADDR_W];
    assign r_fld = in_instr[REG_ADDR_W-1:0];

    always_comb begin
        dec_opcode  = '0;
        dec_aku_en  = 1'b0;
        dec_rd_en   = 1'b0;
        dec_addr    = '0;
        dec_we      = '0;
        dec_illegal = 1'b0;
        if (f_fld <= F_MUL) begin
            dec_opcode = f_fld[OPC_W-1:0];
            dec_aku_en = 1'b1;
        end else if (f_fld == F_RD) begin
            dec_opcode = OPC_W'(6);
            dec_aku_en = 1'b1;
            dec_rd_en  = 1'b1;
            dec_addr   = r_fld;
        end else if (f_fld == F_WR) begin
            dec_we[r_fld] = 1'b1;
            dec_addr      = r_fld;
        end else if ((f_fld == F_NOP) || (f_fld == F_HALT)) begin
            dec_opcode = '0;
        end else begin
            dec_illegal = 1'b1;
        end
    end

    // The output slot and the FSM must both be free before anything is taken.
    assign in_ready = (state_q == ST_RUN) && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        aku_en_d  = aku_en_q;
        rd_en_d   = rd_en_q;
        addr_d    = addr_q;
        we_d      = we_q;
        illegal_d = illegal_q;
        if (accept) begin
            valid_d   = 1'b1;
            opcode_d  = dec_opcode;
            aku_en_d  = dec_aku_en;
            rd_en_d   = dec_rd_en;
            addr_d    = dec_addr;
            we_d      = dec_we;
            illegal_d = dec_illegal;
        end else if (out_ready) begin
            valid_d   = 1'b0;
            opcode_d  = '0;
            aku_en_d  = 1'b0;
            rd_en_d   = 1'b0;
            addr_d    = '0;
            we_d      = '0;
            illegal_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (accept && (f_fld == F_MUL) && MUL_STALL) begin
                    state_d = ST_MUL_WAIT;
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                end else if (accept && (f_fld == F_HALT)) begin
                    state_d = ST_HALTED;
                end
            end
            ST_MUL_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            aku_en_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            we_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            aku_en_q  <= aku_en_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_opcode    = valid_q ? opcode_q  : '0;
    assign out_aku_en    = valid_q && aku_en_q;
    assign out_reg_rd_en = valid_q && rd_en_q;
    assign out_reg_addr  = valid_q ? addr_q    : '0;
    assign out_reg_we    = valid_q ? we_q      : '0;
    assign out_illegal   = valid_q && illegal_q;
    assign halted        = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Self-checking bench for instr_decoder_pipe: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
module tb_instr_decoder_pipe;

    localparam int MUL_LAT = 3;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_opcode;
    logic        out_aku_en;
    logic        out_reg_rd_en;
    logic [1:0]  out_reg_addr;
    logic [3:0]  out_reg_we;
    logic        out_illegal;
    logic        resume;
    logic        halted;
    logic [11:0] obs;

    int n_cmp;
    int n_err;

    instr_decoder_pipe #(
        .REG_ADDR_W(2),
        .OPC_W(3),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr(in_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_opcode(out_opcode),
        .out_aku_en(out_aku_en),
        .out_reg_rd_en(out_reg_rd_en),
        .out_reg_addr(out_reg_addr),
        .out_reg_we(out_reg_we),
        .out_illegal(out_illegal),
        .resume(resume),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {illegal, we[3:0], addr[1:0], rd_en, aku_en, opcode[2:0]}
    assign obs = {out_illegal, out_reg_we, out_reg_addr, out_reg_rd_en, out_aku_en, out_opcode};

    function automatic logic [11:0] ref_decode(input logic [5:0] ins);
        int f;
        int r;
        logic       il;
        logic [3:0] we;
        logic [1:0] addr;
        logic       rd;
        logic       aku;
        logic [2:0] opc;
        f = int'(ins) / 4;
        r = int'(ins) % 4;
        il = 1'b0; we = 4'd0; addr = 2'd0; rd = 1'b0; aku = 1'b0; opc = 3'd0;
        if (f <= 5) begin
            opc = 3'(f); aku = 1'b1;
        end else if (f == 6) begin
            opc = 3'd6; aku = 1'b1; rd = 1'b1; addr = 2'(r);
        end else if (f == 7) begin
            we = 4'(1 << r); addr = 2'(r);
        end else if (f >= 10) begin
            il = 1'b1;
        end
        return {il, we, addr, rd, aku, opc};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_instr = 6'd0; out_ready = 1'b0; resume = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || halted !== 1'b0 || obs !== 12'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset: valid=%b halted=%b payload=%h ready=%b, required 0 0 000 1",
                     out_valid, halted, obs, in_ready);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_decode();
        logic [5:0]  ins_t [6];
        logic [11:0] exp_t [6];
        ins_t[0] = 6'b000100; exp_t[0] = {1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 3'd1};
        ins_t[1] = 6'b011110; exp_t[1] = {1'b0, 4'b0100, 2'd2, 1'b0, 1'b0, 3'd0};
        ins_t[2] = 6'b011001; exp_t[2] = {1'b0, 4'b0000, 2'd1, 1'b1, 1'b1, 3'd6};
        ins_t[3] = 6'b101100; exp_t[3] = {1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 3'd0};
        ins_t[4] = 6'b100011; exp_t[4] = 12'd0;
        ins_t[5] = 6'b001011; exp_t[5] = {1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 3'd2};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); in_valid = 1'b1; in_instr = ins_t[i]; out_ready = 1'b1;
            @(negedge clk); in_valid = 1'b0; #1;
            n_cmp++;
            if (out_valid !== 1'b1 || obs !== exp_t[i] || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL decode %b: valid=%b payload=%h ready=%b, required 1 %h 1",
                         ins_t[i], out_valid, obs, in_ready, exp_t[i]);
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || obs !== 12'd0) begin
            n_err++;
            $display("FAIL decode_drain: valid=%b payload=%h, required 0 000", out_valid, obs);
        end
    endtask

    task automatic test_stall();
        int delivered;
        delivered = 0;
        @(negedge clk); in_valid = 1'b1; in_instr = 6'b000100; out_ready = 1'b0; #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL stall_first_ready: got %b required 1", in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); in_instr = 6'b001000; out_ready = 1'b0; #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== ref_decode(6'b000100)) begin
                n_err++;
                $display("FAIL stall_hold%0d: ready=%b valid=%b payload=%h, required 0 1 %h",
                         i, in_ready, out_valid, obs, ref_decode(6'b000100));
            end
        end
        @(negedge clk); out_ready = 1'b1; #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_opcode !== 3'd1) begin
            n_err++;
            $display("FAIL stall_release: ready=%b valid=%b opcode=%0d, required 1 1 1",
                     in_ready, out_valid, out_opcode);
        end
        if (out_valid === 1'b1) delivered++;
        @(negedge clk); in_valid = 1'b0; #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_opcode !== 3'd2 || out_aku_en !== 1'b1) begin
            n_err++;
            $display("FAIL stall_second: valid=%b opcode=%0d aku=%b, required 1 2 1",
                     out_valid, out_opcode, out_aku_en);
        end
        if (out_valid === 1'b1) delivered++;
        @(negedge clk); #1;
        if (out_valid === 1'b1) delivered++;
        n_cmp++;
        if (delivered !== 2) begin
            n_err++; $display("FAIL stall_count: delivered %0d required 2", delivered);
        end
    endtask

    task automatic test_mul();
        int low;
        low = 0;
        @(negedge clk); in_valid = 1'b1; in_instr = 6'b010100; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b1; in_instr = 6'b000100; #1;
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== {1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 3'd5}) begin
            n_err++;
            $display("FAIL mul_payload: valid=%b payload=%h, required 1 %h",
                     out_valid, obs, {1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 3'd5});
        end
        for (int i = 0; i < 10 && in_ready !== 1'b1; i++) begin
            low++;
            @(negedge clk); #1;
        end
        n_cmp++;
        if (low !== MUL_LAT - 1 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mul_wait: in_ready low %0d cycles, required %0d", low, MUL_LAT - 1);
        end
        @(negedge clk); in_valid = 1'b0; #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_opcode !== 3'd1) begin
            n_err++;
            $display("FAIL mul_next: valid=%b opcode=%0d, required 1 1", out_valid, out_opcode);
        end
    endtask

    task automatic test_halt();
        @(negedge clk); in_valid = 1'b1; in_instr = 6'b100100; out_ready = 1'b1; resume = 1'b1; #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL halt_accept_ready: got %b required 1", in_ready);
        end
        @(negedge clk); in_instr = 6'b000100; resume = 1'b0; #1;
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== 12'd0 || halted !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL halt_enter: valid=%b payload=%h halted=%b ready=%b, required 1 000 1 0",
                     out_valid, obs, halted, in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (halted !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL halt_hold%0d: halted=%b ready=%b valid=%b, required 1 0 0",
                         i, halted, in_ready, out_valid);
            end
        end
        @(negedge clk); in_valid = 1'b0; resume = 1'b1; #1;
        n_cmp++;
        if (halted !== 1'b1) begin
            n_err++; $display("FAIL halt_resume_same: halted=%b required 1", halted);
        end
        @(negedge clk); resume = 1'b0; #1;
        n_cmp++;
        if (halted !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL halt_resume: halted=%b ready=%b, required 0 1", halted, in_ready);
        end
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk); in_valid = 1'b1; in_instr = 6'b010111; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0; #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL rstmul_wait: ready=%b required 0", in_ready);
        end
        rst = 1'b1; #1;
        n_cmp++;
        if (out_valid !== 1'b0 || obs !== 12'd0 || halted !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstmul_async: valid=%b payload=%h halted=%b ready=%b, required 0 000 0 1",
                     out_valid, obs, halted, in_ready);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_instr = 6'b000100; #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmul_release: ready=%b valid=%b, required 1 0", in_ready, out_valid);
        end
        @(negedge clk); in_valid = 1'b0; #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_opcode !== 3'd1) begin
            n_err++;
            $display("FAIL rstmul_after: ready=%b valid=%b opcode=%0d, required 1 1 1",
                     in_ready, out_valid, out_opcode);
        end
    endtask

    // Model: output slot contents, halt flag, and the first cycle a multiply frees the ALU.
    task automatic test_random();
        int          cyc;
        int          mul_free;
        bit          hm;
        bit          vm;
        logic [11:0] pm;
        bit          exp_rdy;
        bit          rv;
        bit          orr;
        bit          res;
        logic [5:0]  ins;
        @(negedge clk); rst = 1'b1; in_valid = 1'b0; resume = 1'b0;
        @(negedge clk); rst = 1'b0;
        cyc = 0; mul_free = 0; hm = 1'b0; vm = 1'b0; pm = 12'd0;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            rv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 9) < 7);
            res = ($urandom_range(0, 9) == 0);
            ins = 6'($urandom_range(0, 63));
            in_valid = rv; in_instr = ins; out_ready = orr; resume = res;
            #1;
            exp_rdy = !hm && (cyc >= mul_free) && (!vm || orr);
            n_cmp++;
            if (in_ready !== exp_rdy || halted !== hm) begin
                n_err++;
                $display("FAIL rand_ctrl cyc%0d: ready=%b halted=%b, required %b %b",
                         cyc, in_ready, halted, exp_rdy, hm);
            end
            n_cmp++;
            if (out_valid !== vm || obs !== pm) begin
                n_err++;
                $display("FAIL rand_out cyc%0d: valid=%b payload=%h, required %b %h",
                         cyc, out_valid, obs, vm, pm);
            end
            if (hm && res) hm = 1'b0;
            if (rv && exp_rdy) begin
                vm = 1'b1;
                pm = ref_decode(ins);
                if (int'(ins) / 4 == 5) mul_free = cyc + MUL_LAT;
                if (int'(ins) / 4 == 9) hm = 1'b1;
            end else if (orr) begin
                vm = 1'b0;
                pm = 12'd0;
            end
            cyc++;
        end
        in_valid = 1'b0; resume = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; in_valid = 1'b0; in_instr = 6'd0; out_ready = 1'b0; resume = 1'b0;
        test_reset();
        test_decode();
        test_stall();
        test_mul();
        test_halt();
        test_reset_mid_mul();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
